// File: rtl/memoria_responder_pkg.sv
// rtl/memoria_responder_pkg.sv - shared widths, FSM states and bank codes for the memory responder
package memoria_responder_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } loaderState_t;

  localparam logic BANK_INSTR = 1'b0;
  localparam logic BANK_DATA  = 1'b1;

  typedef logic [ADDR_W-1:0] memAddr_t;
  typedef logic [DATA_W-1:0] memWord_t;

  // The byte accepted at this address closes the image.
  function automatic logic isLastAddr(input memAddr_t addr);
    return addr == ADDR_W'(DEPTH - 1);
  endfunction

endpackage

// File: rtl/memoria_responder_if.sv
// rtl/memoria_responder_if.sv - CPU instruction/data buses plus host loader handshake
interface memoria_responder_if;
  import memoria_responder_pkg::*;

  memAddr_t instMemAddrBus;
  memWord_t instMemDataBus;
  memAddr_t dataMemAddrBus;
  memWord_t dataMemInDataBus;
  logic     dm_we;
  memWord_t dataMemOutDataBus;

  logic     load_start;
  logic     load_sel;
  logic     load_valid;
  memWord_t load_data;
  logic     load_ready;
  memAddr_t load_addr;
  logic     load_done;
  logic     cpu_hold;

  // master: CPU and host side; slave: the responder
  modport master (
    output instMemAddrBus, dataMemAddrBus, dataMemInDataBus, dm_we,
    output load_start, load_sel, load_valid, load_data,
    input  instMemDataBus, dataMemOutDataBus,
    input  load_ready, load_addr, load_done, cpu_hold
  );

  modport slave (
    input  instMemAddrBus, dataMemAddrBus, dataMemInDataBus, dm_we,
    input  load_start, load_sel, load_valid, load_data,
    output instMemDataBus, dataMemOutDataBus,
    output load_ready, load_addr, load_done, cpu_hold
  );

endinterface

// File: rtl/memoria_responder_banco_memoria.sv
// rtl/memoria_responder_banco_memoria.sv - register-array bank, async read, sync write and clear
module banco_memoria
  import memoria_responder_pkg::*;
(
  input  logic     clock,
  input  logic     clear,
  input  logic     wrEn,
  input  memAddr_t wrAddr,
  input  memWord_t wrData,
  input  memAddr_t rdAddr,
  output memWord_t rdData
);

  memWord_t mem [DEPTH];

  // Clear beats a concurrent write so reset owns the bank for that edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/memoria_responder.sv
// rtl/memoria_responder.sv - instruction/data memory responder with host image loader and CPU hold
module memoria_responder
  import memoria_responder_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  memoria_responder_if.slave  bus
);

  loaderState_t state, nextState;
  memAddr_t     loadAddr, nextAddr;
  logic         loadDone, nextDone;

  logic         instWe, dataWe;
  memAddr_t     dataWrAddr;
  memWord_t     dataWrData;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RUN;
      loadAddr <= '0;
      loadDone <= 1'b0;
    end else begin
      state    <= nextState;
      loadAddr <= nextAddr;
      loadDone <= nextDone;
    end
  end

  always_comb begin
    nextState  = state;
    nextAddr   = loadAddr;
    nextDone   = 1'b0;
    instWe     = 1'b0;
    dataWe     = 1'b0;
    dataWrAddr = bus.dataMemAddrBus;
    dataWrData = bus.dataMemInDataBus;

    case (state)
      ST_RUN: begin
        dataWe = bus.dm_we;
        if (bus.load_start) begin
          nextState = ST_LOAD;
          nextAddr  = '0;
        end
      end

      ST_LOAD: begin
        dataWrAddr = loadAddr;
        dataWrData = bus.load_data;
        // A restart discards whatever byte arrives alongside it.
        if (bus.load_start) begin
          nextAddr = '0;
        end else if (bus.load_valid) begin
          instWe   = (bus.load_sel == BANK_INSTR);
          dataWe   = (bus.load_sel == BANK_DATA);
          nextAddr = loadAddr + ADDR_W'(1);
          if (isLastAddr(loadAddr)) begin
            nextState = ST_RUN;
            nextDone  = 1'b1;
          end
        end
      end

      default: begin
        nextState = ST_RUN;
      end
    endcase
  end

  // Instruction bank survives reset, so reset only needs to mask its write.
  banco_memoria instBank (
    .clock  (clock),
    .clear  (1'b0),
    .wrEn   (instWe & ~reset),
    .wrAddr (loadAddr),
    .wrData (bus.load_data),
    .rdAddr (bus.instMemAddrBus),
    .rdData (bus.instMemDataBus)
  );

  banco_memoria dataBank (
    .clock  (clock),
    .clear  (reset),
    .wrEn   (dataWe),
    .wrAddr (dataWrAddr),
    .wrData (dataWrData),
    .rdAddr (bus.dataMemAddrBus),
    .rdData (bus.dataMemOutDataBus)
  );

  assign bus.cpu_hold   = (state == ST_LOAD);
  assign bus.load_ready = (state == ST_LOAD);
  assign bus.load_addr  = loadAddr;
  assign bus.load_done  = loadDone;

endmodule

// File: tb/tb_memoria_responder.sv
// tb/tb_memoria_responder.sv - directed-vector bench for memoria_responder
module tb_memoria_responder;
  import memoria_responder_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   doneCount = 0;

  memoria_responder_if bus ();

  memoria_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.load_done === 1'b1) doneCount++;
  end

  task automatic checkVector(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic loadByte(input logic sel, input logic [7:0] d);
    bus.load_sel   = sel;
    bus.load_data  = d;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic startLoad();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic readInst(input int a, output logic [7:0] d);
    bus.instMemAddrBus = 4'(a);
    #1;
    d = bus.instMemDataBus;
  endtask

  task automatic readData(input int a, output logic [7:0] d);
    bus.dataMemAddrBus = 4'(a);
    #1;
    d = bus.dataMemOutDataBus;
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] exp;
    int doneBase;

    bus.instMemAddrBus   = '0;
    bus.dataMemAddrBus   = '0;
    bus.dataMemInDataBus = '0;
    bus.dm_we            = 1'b0;
    bus.load_start       = 1'b0;
    bus.load_sel         = 1'b0;
    bus.load_valid       = 1'b0;
    bus.load_data        = '0;

    // Reset, with a write and a start that reset must override
    bus.dm_we = 1'b1; bus.dataMemAddrBus = 4'h3; bus.dataMemInDataBus = 8'h77; bus.load_start = 1'b1;
    step(); step();
    bus.dm_we = 1'b0; bus.load_start = 1'b0;
    reset = 1'b0;
    #1;
    checkVector("rst_cpu_hold", 32'(bus.cpu_hold), 32'(0));
    checkVector("rst_load_ready", 32'(bus.load_ready), 32'(0));
    checkVector("rst_load_done", 32'(bus.load_done), 32'(0));
    checkVector("rst_load_addr", 32'(bus.load_addr), 32'(0));
    for (int a = 0; a < 16; a += 5) begin
      readData(a, rd);
      checkVector($sformatf("rst_data[%0d]", a), 32'(rd), 32'(0));
    end

    // Full instruction load 10..1F
    doneBase = doneCount;
    startLoad();
    checkVector("ld_cpu_hold", 32'(bus.cpu_hold), 32'(1));
    checkVector("ld_load_ready", 32'(bus.load_ready), 32'(1));
    for (int i = 0; i < 16; i++) begin
      checkVector($sformatf("ld_addr_%0d", i), 32'(bus.load_addr), 32'(i));
      loadByte(BANK_INSTR, 8'(8'h10 + i));
      if (i < 15) checkVector($sformatf("ld_no_done_%0d", i), 32'(bus.load_done), 32'(0));
    end
    checkVector("ld_done_pulse", 32'(bus.load_done), 32'(1));
    checkVector("ld_hold_released", 32'(bus.cpu_hold), 32'(0));
    checkVector("ld_addr_wrapped", 32'(bus.load_addr), 32'(0));
    step();
    checkVector("ld_done_one_cycle", 32'(bus.load_done), 32'(0));
    for (int i = 0; i < 16; i++) begin
      readInst(i, rd);
      checkVector($sformatf("instr[%0d]", i), 32'(rd), 32'(8'h10 + i));
    end

    // CPU write in ST_RUN: read-during-write returns old word
    bus.dataMemAddrBus = 4'h7; bus.dataMemInDataBus = 8'hA5; bus.dm_we = 1'b1;
    #1;
    checkVector("rdw_old", 32'(bus.dataMemOutDataBus), 32'(8'h00));
    step();
    bus.dm_we = 1'b0;
    #1;
    checkVector("wr_new", 32'(bus.dataMemOutDataBus), 32'(8'hA5));

    // dm_we ignored while loading
    startLoad();
    bus.dataMemAddrBus = 4'h7; bus.dataMemInDataBus = 8'h3C; bus.dm_we = 1'b1;
    step();
    bus.dm_we = 1'b0;
    #1;
    checkVector("load_blocks_dm_we", 32'(bus.dataMemOutDataBus), 32'(8'hA5));

    // Interrupt after 5 data bytes with a concurrent byte
    doneBase = doneCount;
    for (int i = 0; i < 5; i++) loadByte(BANK_DATA, 8'(8'h50 + i));
    checkVector("intr_addr5", 32'(bus.load_addr), 32'(5));
    bus.load_start = 1'b1; bus.load_valid = 1'b1; bus.load_sel = BANK_DATA; bus.load_data = 8'hEE;
    step();
    bus.load_start = 1'b0; bus.load_valid = 1'b0;
    #1;
    checkVector("intr_addr0", 32'(bus.load_addr), 32'(0));
    checkVector("intr_hold", 32'(bus.cpu_hold), 32'(1));
    readData(5, rd);
    checkVector("intr_dropped", 32'(rd), 32'(8'h00));
    readData(0, rd);
    checkVector("intr_kept", 32'(rd), 32'(8'h50));
    for (int i = 0; i < 16; i++) begin
      loadByte(BANK_DATA, 8'(8'h60 + i));
      if (i % 3 == 1) step();
    end
    step(); step();
    checkVector("intr_single_done", 32'(doneCount - doneBase), 32'(1));
    checkVector("intr_back_run", 32'(bus.cpu_hold), 32'(0));
    for (int i = 0; i < 16; i += 3) begin
      readData(i, rd);
      checkVector($sformatf("intr_data[%0d]", i), 32'(rd), 32'(8'h60 + i));
    end

    // Reset after 8 instruction bytes
    doneBase = doneCount;
    startLoad();
    for (int i = 0; i < 8; i++) loadByte(BANK_INSTR, 8'(8'h80 + i));
    reset = 1'b1;
    bus.load_valid = 1'b1; bus.load_data = 8'hFF; bus.load_sel = BANK_INSTR;
    step();
    reset = 1'b0; bus.load_valid = 1'b0;
    #1;
    checkVector("mid_rst_hold", 32'(bus.cpu_hold), 32'(0));
    checkVector("mid_rst_ready", 32'(bus.load_ready), 32'(0));
    checkVector("mid_rst_addr", 32'(bus.load_addr), 32'(0));
    step(); step();
    checkVector("mid_rst_no_done", 32'(doneCount - doneBase), 32'(0));
    for (int i = 0; i < 16; i++) begin
      readInst(i, rd);
      exp = (i < 8) ? 8'(8'h80 + i) : 8'(8'h10 + i);
      checkVector($sformatf("mid_rst_instr[%0d]", i), 32'(rd), 32'(exp));
    end
    for (int i = 0; i < 16; i += 4) begin
      readData(i, rd);
      checkVector($sformatf("mid_rst_data[%0d]", i), 32'(rd), 32'(0));
    end

    // Mixed-bank load
    doneBase = doneCount;
    startLoad();
    for (int i = 0; i < 16; i++) loadByte(i[0], 8'(8'hC0 + i));
    checkVector("mix_done", 32'(bus.load_done), 32'(1));
    step();
    for (int i = 0; i < 16; i++) begin
      readInst(i, rd);
      if (i[0] == 1'b0) exp = 8'(8'hC0 + i);
      else if (i < 8)   exp = 8'(8'h80 + i);
      else              exp = 8'(8'h10 + i);
      checkVector($sformatf("mix_instr[%0d]", i), 32'(rd), 32'(exp));
      readData(i, rd);
      exp = (i[0] == 1'b1) ? 8'(8'hC0 + i) : 8'h00;
      checkVector($sformatf("mix_data[%0d]", i), 32'(rd), 32'(exp));
    end
    checkVector("mix_single_done", 32'(doneCount - doneBase), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
